stream_demux_1to2: RTL and testbench

- Registered 1-to-2 stream demultiplexer: the steering counterpart of the 2:1 mux. It takes one valid/ready stream and routes each beat to output port 0 or 1.
- The port is chosen per packet: `in_sel` is sampled on the first beat and held until the beat carrying `in_last` is accepted.
- Each output has a one-entry register stage. Sits between a shared producer and two consumers in the datapath.

---
 rtl/stream_demux_pkg.sv | 22 ++
 rtl/stream_out_reg.sv | 54 +++++
 rtl/stream_demux_1to2.sv | 134 +++++++++++++
 tb/tb_stream_demux_1to2.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared types and constants for the 1-to-2 stream demux.
//               demux_state_t : packet FSM state (IDLE / LOCK)
//               PORT0, PORT1  : route encodings for the two outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } demux_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/stream_out_reg.sv
// ============================================================================
// Module      : stream_out_reg
// Description : One-entry valid/data/last output register stage.
//               A load always takes priority over a drain, so a load and a
//               drain in the same cycle keep valid high and give 1 beat/clk.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               load, load_data,
//               load_last         - write a new beat into the stage
//               ready             - downstream consumer ready
//               valid, data, last - registered stream outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
      r_last  <= load_last;
    end else if (r_valid && ready) begin
      // Payload holds its last value after drain; only valid drops.
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign last  = r_last;

endmodule

`default_nettype wire

// File: rtl/stream_demux_1to2.sv
// ============================================================================
// Module      : stream_demux_1to2
// Description : Registered 1-to-2 valid/ready stream demultiplexer. The
//               destination is sampled from in_sel on the first beat of a
//               packet and held until the in_last beat is accepted.
// Ports       : clk, rst                      - clock, sync active-high reset
//               in_valid/ready/data/last/sel  - source stream + port select
//               outN_valid/ready/data/last    - output streams, N = 0, 1
//               beat_cnt0, beat_cnt1          - wrapping accepted-beat counts
//               pkt_active                    - high while a packet is locked
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic [CNT_W-1:0]  beat_cnt0,
  output logic [CNT_W-1:0]  beat_cnt1,
  output logic              pkt_active
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  demux_state_t     r_state;
  demux_state_t     w_state_nxt;
  logic             r_locked_sel;
  logic             w_locked_sel_nxt;
  logic             w_route;
  logic             w_accept;
  logic             w_load0;
  logic             w_load1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // in_sel only matters for the first beat; mid-packet the latched port wins.
  assign w_route = (r_state == IDLE) ? in_sel : r_locked_sel;

  // Only path from outputs back to input is the routed port's ready.
  assign in_ready = (w_route == PORT0) ? (!out0_valid || out0_ready)
                                       : (!out1_valid || out1_ready);
  assign w_accept = in_valid && in_ready;
  assign w_load0  = w_accept && (w_route == PORT0);
  assign w_load1  = w_accept && (w_route == PORT1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_locked_sel <= PORT0;
    end else begin
      r_state      <= w_state_nxt;
      r_locked_sel <= w_locked_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_locked_sel_nxt = r_locked_sel;
    case (r_state)
      IDLE: begin
        // A single-beat packet never leaves IDLE.
        if (w_accept && !in_last) begin
          w_state_nxt      = LOCK;
          w_locked_sel_nxt = in_sel;
        end
      end
      LOCK: begin
        if (w_accept && in_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_load0) r_cnt0 <= r_cnt0 + C_CNT_ONE;
      if (w_load1) r_cnt1 <= r_cnt1 + C_CNT_ONE;
    end
  end

  stream_out_reg #(.DATA_W(DATA_W)) u_out0 (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load0),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .last      (out0_last)
  );

  stream_out_reg #(.DATA_W(DATA_W)) u_out1 (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load1),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .last      (out1_last)
  );

  assign beat_cnt0  = r_cnt0;
  assign beat_cnt1  = r_cnt1;
  assign pkt_active = (r_state == LOCK);

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
// ============================================================================
// Module      : tb_stream_demux_1to2
// Description : Self-checking bench for stream_demux_1to2. Expected beats are
//               queued per port on accept and compared as each output drains.
//               A second instance with CNT_W=4 shares the stimulus to observe
//               counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_demux_1to2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_sel = 1'b0;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b1;
  logic        out1_ready = 1'b1;
  logic [7:0]  out0_data, out1_data;
  logic        out0_last, out1_last;
  logic [15:0] beat_cnt0, beat_cnt1;
  logic        pkt_active;

  logic        s_in_ready, s_out0_valid, s_out0_last, s_out1_valid, s_out1_last, s_pkt_active;
  logic [7:0]  s_out0_data, s_out1_data;
  logic [3:0]  s_beat_cnt0, s_beat_cnt1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       m_active = 1'b0;
  logic       m_locked = 1'b0;
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_last(out0_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_last(out1_last),
    .beat_cnt0(beat_cnt0), .beat_cnt1(beat_cnt1), .pkt_active(pkt_active)
  );

  stream_demux_1to2 #(.DATA_W(8), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out0_valid(s_out0_valid), .out0_ready(out0_ready), .out0_data(s_out0_data), .out0_last(s_out0_last),
    .out1_valid(s_out1_valid), .out1_ready(out1_ready), .out1_data(s_out1_data), .out1_last(s_out1_last),
    .beat_cnt0(s_beat_cnt0), .beat_cnt1(s_beat_cnt1), .pkt_active(s_pkt_active)
  );

  // Output monitor: a transfer happens at the next rising edge when valid&&ready.
  always @(negedge clk) begin
    logic [8:0] exp0, exp1;
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL port0_unexpected_beat got data=%h last=%b, no beat expected", out0_data, out0_last);
        end else begin
          exp0 = q0.pop_front();
          if ({out0_last, out0_data} !== exp0) begin
            errors++;
            $display("FAIL port0_beat got last=%b data=%h, want last=%b data=%h",
                     out0_last, out0_data, exp0[8], exp0[7:0]);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL port1_unexpected_beat got data=%h last=%b, no beat expected", out1_data, out1_last);
        end else begin
          exp1 = q1.pop_front();
          if ({out1_last, out1_data} !== exp1) begin
            errors++;
            $display("FAIL port1_beat got last=%b data=%h, want last=%b data=%h",
                     out1_last, out1_data, exp1[8], exp1[7:0]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
    m_active = 1'b0; m_locked = 1'b0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Presents one beat and waits (bounded) for acceptance; leaves in_valid high
  // so the caller can chain beats back to back. Returns at posedge+1.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic s, output int waits);
    logic r;
    logic done;
    in_valid = 1'b1; in_data = d; in_last = l; in_sel = s;
    r = m_active ? m_locked : s;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (r) begin q1.push_back({l, d}); m_cnt1++; end
        else   begin q0.push_back({l, d}); m_cnt0++; end
        if (!m_active && !l) begin m_active = 1'b1; m_locked = s; end
        else if (m_active && l) m_active = 1'b0;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          checks++; errors++;
          $display("FAIL accept_timeout data=%h never accepted after %0d cycles", d, waits);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    int w;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check_bit("reset_out0_valid", out0_valid, 1'b0);
    check_bit("reset_out1_valid", out1_valid, 1'b0);
    check_bit("reset_pkt_active", pkt_active, 1'b0);
    check_cnt("reset_beat_cnt0", beat_cnt0, 16'd0);
    check_cnt("reset_beat_cnt1", beat_cnt1, 16'd0);
    @(posedge clk); #1;
    // Reset in the middle of a 4-beat packet bound for port 1.
    out0_ready = 1'b1; out1_ready = 1'b1;
    send_beat(8'h61, 1'b0, 1'b1, w);
    send_beat(8'h62, 1'b0, 1'b1, w);
    in_valid = 1'b0; out1_ready = 1'b0;
    @(negedge clk);
    check_bit("midpkt_out1_valid_held", out1_valid, 1'b1);
    check_bit("midpkt_pkt_active", pkt_active, 1'b1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check_bit("post_rst_out1_valid", out1_valid, 1'b0);
    check_bit("post_rst_pkt_active", pkt_active, 1'b0);
    check_cnt("post_rst_beat_cnt1", beat_cnt1, 16'd0);
    @(posedge clk); #1;
    out1_ready = 1'b1;
    send_beat(8'h70, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("post_rst_new_pkt_port0", out0_valid && (out0_data == 8'h70), 1'b1);
    check_bit("post_rst_new_pkt_not_port1", out1_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_single_alternate();
    int w;
    logic [7:0] dat [4];
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(dat[i], 1'b1, i[0], w);
      in_valid = 1'b0;
      check_bit("single_pkt_active", pkt_active, 1'b0);
      @(negedge clk);
      if (i[0]) check_bit("single_latency_port1", out1_valid && !out0_valid && (out1_data == dat[i]), 1'b1);
      else      check_bit("single_latency_port0", out0_valid && !out1_valid && (out0_data == dat[i]), 1'b1);
      @(posedge clk); #1;
    end
    check_cnt("single_beat_cnt0", beat_cnt0, 16'd2);
    check_cnt("single_beat_cnt1", beat_cnt1, 16'd2);
  endtask

  task automatic test_packet_lock();
    int w;
    out0_ready = 1'b1; out1_ready = 1'b1;
    send_beat(8'hB0, 1'b0, 1'b1, w);
    check_bit("lock_active_after_beat0", pkt_active, 1'b1);
    send_beat(8'hB1, 1'b0, 1'b0, w);
    check_bit("lock_active_after_beat1", pkt_active, 1'b1);
    send_beat(8'hB2, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    check_bit("lock_idle_after_last", pkt_active, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_cnt("lock_beat_cnt0", beat_cnt0, m_cnt0[15:0]);
    check_cnt("lock_beat_cnt1", beat_cnt1, m_cnt1[15:0]);
    check_bit("lock_queues_drained", (q0.size() == 0) && (q1.size() == 0), 1'b1);
  endtask

  task automatic test_backpressure();
    int w;
    int total_waits;
    do_reset();
    out0_ready = 1'b0; out1_ready = 1'b0;
    send_beat(8'h5A, 1'b1, 1'b0, w);
    send_beat(8'h5B, 1'b1, 1'b1, w);
    // New packet for blocked port 1 must stall.
    in_valid = 1'b1; in_data = 8'hA0; in_last = 1'b0; in_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("bp_in_ready_low", in_ready, 1'b0);
      checks++;
      if (out1_data !== 8'h5B || out1_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_out1_stable got valid=%b data=%h want valid=1 data=5b", out1_valid, out1_data);
      end
      @(posedge clk); #1;
      if (i == 1) out0_ready = 1'b1;
    end
    check_bit("bp_port0_drained", out0_valid, 1'b0);
    out1_ready = 1'b1;
    #1;
    check_bit("bp_in_ready_same_cycle", in_ready, 1'b1);
    total_waits = 0;
    send_beat(8'hA0, 1'b0, 1'b1, w); total_waits += w;
    send_beat(8'hA1, 1'b0, 1'b0, w); total_waits += w;
    send_beat(8'hA2, 1'b0, 1'b0, w); total_waits += w;
    send_beat(8'hA3, 1'b1, 1'b0, w); total_waits += w;
    in_valid = 1'b0;
    check_cnt("bp_full_throughput_stalls", total_waits[15:0], 16'd0);
    repeat (2) @(posedge clk);
    #1;
    check_cnt("bp_beat_cnt1", beat_cnt1, 16'd5);
  endtask

  task automatic test_back_to_back();
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    fork
      begin
        int w;
        for (int i = 0; i < 8; i++) send_beat(8'hC0 + 8'(i), (i == 7), 1'b0, w);
        in_valid = 1'b0;
      end
      begin
        int bound;
        bound = 0;
        @(negedge clk);
        while (!out0_valid && bound < 20) begin @(negedge clk); bound++; end
        for (int k = 0; k < 8; k++) begin
          check_bit("b2b_out0_valid_no_bubble", out0_valid, 1'b1);
          @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;
    check_cnt("b2b_beat_cnt0", beat_cnt0, 16'd8);
  endtask

  task automatic test_counter_wrap();
    int w;
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_beat(8'(i), 1'b1, 1'b0, w);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_beat_cnt0 !== 4'd1) begin
      errors++;
      $display("FAIL wrap_beat_cnt0_w4 got %0d want 1", s_beat_cnt0);
    end
    check_cnt("wrap_beat_cnt0_w16", beat_cnt0, 16'd17);
  endtask

  initial begin
    test_reset();
    test_single_alternate();
    test_packet_lock();
    test_backpressure();
    test_back_to_back();
    test_counter_wrap();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL final_queues_empty got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
